// File: rtl/array_drain_reader_if.sv
// Bundle of the writer port, drain handshake and status for array_drain_reader.
// out_parity exists only when ARRAY_DRAIN_READER_PARITY_EN is defined.
interface array_drain_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_start;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              busy;
    logic [CNT_W-1:0]  rd_cnt;
    logic              overwrite_err;
`ifdef ARRAY_DRAIN_READER_PARITY_EN
    logic              out_parity;
`endif

    modport master (
        output wr_en, wr_addr, wr_data, rd_start, out_ready,
        input  out_valid, out_data, out_addr, busy, rd_cnt, overwrite_err
`ifdef ARRAY_DRAIN_READER_PARITY_EN
        , input out_parity
`endif
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_start, out_ready,
        output out_valid, out_data, out_addr, busy, rd_cnt, overwrite_err
`ifdef ARRAY_DRAIN_READER_PARITY_EN
        , output out_parity
`endif
    );
endinterface

// File: rtl/array_drain_reader.sv
// Drains a writer-filled DEPTH-entry array in address order, one word per handshake.
// Latency: rd_start or a handshake to next out_valid is 2 cycles when the entry is valid.
// Backpressure: out_data/out_addr hold in SEND until out_ready; SCAN waits for the writer.
// Optional out_parity port enabled by ARRAY_DRAIN_READER_PARITY_EN.
module array_drain_reader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    array_drain_reader_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SCAN, SEND} state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [ADDR_W-1:0] rd_ptr;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic              overwrite_err_q;
    logic              start, load, retire;

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        load    = 1'b0;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.rd_start) begin
                    start   = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (valid_q[rd_ptr]) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    retire  = 1'b1;
                    state_d = (rd_ptr == LAST_PTR) ? IDLE : SCAN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Array storage is deliberately unreset; valid_q guards every read.
    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q         <= '0;
            rd_ptr          <= '0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_addr_q      <= '0;
            rd_cnt_q        <= '0;
            overwrite_err_q <= 1'b0;
        end else begin
            if (start) begin
                rd_ptr <= '0;
            end
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= mem[rd_ptr];
                out_addr_q  <= rd_ptr;
            end
            if (retire) begin
                out_valid_q     <= 1'b0;
                rd_cnt_q        <= rd_cnt_q + 1'b1;
                valid_q[rd_ptr] <= 1'b0;
                if (rd_ptr != LAST_PTR) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            // A write landing on the entry being retired wins and is not an overwrite.
            if (bus.wr_en) begin
                valid_q[bus.wr_addr] <= 1'b1;
                if (valid_q[bus.wr_addr] && !(retire && bus.wr_addr == rd_ptr)) begin
                    overwrite_err_q <= 1'b1;
                end
            end
        end
    end

`ifdef ARRAY_DRAIN_READER_PARITY_EN
    logic out_parity_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_parity_q <= 1'b0;
        end else if (load) begin
            out_parity_q <= ^mem[rd_ptr];
        end
    end

    assign bus.out_parity = out_parity_q;
`endif

    assign bus.out_valid     = out_valid_q;
    assign bus.out_data      = out_data_q;
    assign bus.out_addr      = out_addr_q;
    assign bus.busy          = (state_q != IDLE);
    assign bus.rd_cnt        = rd_cnt_q;
    assign bus.overwrite_err = overwrite_err_q;
endmodule

// File: tb/tb_array_drain_reader.sv
// Scoreboard bench for array_drain_reader: expected words queued at write time, checked on handshake.
module tb_array_drain_reader;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam int CNT_W  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;

    array_drain_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    array_drain_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    logic [CNT_W-1:0]  exp_cnt = '0;
    logic [ADDR_W-1:0] q_addr[$];
    logic [DATA_W-1:0] q_data[$];

    // Inputs only change just after posedge, so a handshake seen here is taken at the next edge.
    always @(negedge clk) begin
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        if (reset) begin
            exp_cnt = '0;
        end else if (bus.out_valid && bus.out_ready) begin
            hs_cnt++;
            exp_cnt++;
            checks++;
            if (q_addr.size() == 0) begin
                errors++;
                $display("FAIL handshake_unexpected: got addr %0d data %h, required no word", bus.out_addr, bus.out_data);
            end else begin
                ea = q_addr.pop_front();
                ed = q_data.pop_front();
                if (bus.out_addr !== ea || bus.out_data !== ed) begin
                    errors++;
                    $display("FAIL handshake_word: got addr %0d data %h, required addr %0d data %h", bus.out_addr, bus.out_data, ea, ed);
                end
            end
`ifdef ARRAY_DRAIN_READER_PARITY_EN
            checks++;
            if (bus.out_parity !== ^ed) begin
                errors++;
                $display("FAIL out_parity: got %b required %b", bus.out_parity, ^ed);
            end
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    task automatic expect_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        q_addr.push_back(a);
        q_data.push_back(d);
    endtask

    task automatic start_pass();
        bus.rd_start = 1'b1;
        step();
        bus.rd_start = 1'b0;
    endtask

    task automatic wait_hs(input int target, input int budget, output bit ok);
        int n = 0;
        while (hs_cnt < target && n < budget) begin
            step();
            n++;
        end
        ok = (hs_cnt >= target);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        int n = 0;
        while (!bus.out_valid && n < budget) begin
            step();
            n++;
        end
        ok = bus.out_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h required 0", bus.out_data); end
        checks++; if (bus.out_addr !== '0) begin errors++; $display("FAIL reset_out_addr: got %0d required 0", bus.out_addr); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        checks++; if (bus.rd_cnt !== '0) begin errors++; $display("FAIL reset_rd_cnt: got %0d required 0", bus.rd_cnt); end
        checks++; if (bus.overwrite_err !== 1'b0) begin errors++; $display("FAIL reset_overwrite_err: got %b required 0", bus.overwrite_err); end
`ifdef ARRAY_DRAIN_READER_PARITY_EN
        checks++; if (bus.out_parity !== 1'b0) begin errors++; $display("FAIL reset_out_parity: got %b required 0", bus.out_parity); end
`endif
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic_pass();
        bit ok;
        int target;
        for (int i = 0; i < 4; i++) begin
            write_word(ADDR_W'(i), 32'h11 * (i + 1));
            expect_word(ADDR_W'(i), 32'h11 * (i + 1));
        end
        target = hs_cnt + 4;
        bus.out_ready = 1'b1;
        start_pass();
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL basic_scan: got valid %b busy %b required 0 1", bus.out_valid, bus.busy); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 2'd0) begin errors++; $display("FAIL basic_first_latency: got valid %b addr %0d required 1 0", bus.out_valid, bus.out_addr); end
        wait_hs(target, 40, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got %0d handshakes required %0d", hs_cnt, target); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after_last: got %b required 0", bus.busy); end
        checks++; if (bus.rd_cnt !== 8'd4) begin errors++; $display("FAIL basic_rd_cnt: got %0d required 4", bus.rd_cnt); end
        checks++; if (q_addr.size() != 0) begin errors++; $display("FAIL basic_leftover: got %0d words pending required 0", q_addr.size()); end
    endtask

    task automatic test_writer_paced();
        bit ok;
        int target;
        bus.out_ready = 1'b1;
        start_pass();
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL paced_wait_scan: got valid %b busy %b required 0 1", bus.out_valid, bus.busy); end
            step();
        end
        expect_word(2'd0, 32'hA5A5A5A5);
        target = hs_cnt + 4;
        write_word(2'd0, 32'hA5A5A5A5);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL paced_no_bypass: got %b required 0", bus.out_valid); end
        step();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA5A5A5A5) begin errors++; $display("FAIL paced_rise: got valid %b data %h required 1 a5a5a5a5", bus.out_valid, bus.out_data); end
        for (int i = 1; i < 4; i++) begin
            expect_word(ADDR_W'(i), 32'hB0 + i);
            write_word(ADDR_W'(i), 32'hB0 + i);
        end
        wait_hs(target, 40, ok);
        checks++; if (!ok || bus.busy !== 1'b0) begin errors++; $display("FAIL paced_complete: got ok %b busy %b required 1 0", ok, bus.busy); end
        checks++; if (bus.overwrite_err !== 1'b0) begin errors++; $display("FAIL paced_overwrite_err: got %b required 0", bus.overwrite_err); end
        checks++; if (bus.rd_cnt !== exp_cnt) begin errors++; $display("FAIL paced_rd_cnt: got %0d required %0d", bus.rd_cnt, exp_cnt); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int target;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            write_word(ADDR_W'(i), 32'h11 * (i + 1));
            expect_word(ADDR_W'(i), 32'h11 * (i + 1));
        end
        target = hs_cnt + 4;
        start_pass();
        wait_valid(10, ok);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        wait_valid(10, ok);
        checks++; if (!ok || bus.out_addr !== 2'd1) begin errors++; $display("FAIL bp_reach_addr1: got valid %b addr %0d required 1 1", ok, bus.out_addr); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h22 || bus.out_addr !== 2'd1) begin errors++; $display("FAIL bp_hold: got valid %b data %h addr %0d required 1 22 1", bus.out_valid, bus.out_data, bus.out_addr); end
            step();
        end
        bus.out_ready = 1'b1;
        write_word(2'd1, 32'h99);
        checks++; if (bus.overwrite_err !== 1'b0) begin errors++; $display("FAIL bp_retire_write_err: got %b required 0", bus.overwrite_err); end
        wait_hs(target, 40, ok);
        checks++; if (!ok || bus.busy !== 1'b0) begin errors++; $display("FAIL bp_complete: got ok %b busy %b required 1 0", ok, bus.busy); end
        // Entry 1 must still hold the winning write; entries 0, 2, 3 are refilled.
        expect_word(2'd0, 32'h77);
        expect_word(2'd1, 32'h99);
        expect_word(2'd2, 32'h78);
        expect_word(2'd3, 32'h79);
        write_word(2'd0, 32'h77);
        write_word(2'd2, 32'h78);
        write_word(2'd3, 32'h79);
        checks++; if (bus.overwrite_err !== 1'b0) begin errors++; $display("FAIL bp_refill_err: got %b required 0", bus.overwrite_err); end
        target = hs_cnt + 4;
        start_pass();
        wait_hs(target, 40, ok);
        checks++; if (!ok || q_addr.size() != 0) begin errors++; $display("FAIL bp_second_pass: got ok %b pending %0d required 1 0", ok, q_addr.size()); end
        checks++; if (bus.rd_cnt !== exp_cnt) begin errors++; $display("FAIL bp_rd_cnt: got %0d required %0d", bus.rd_cnt, exp_cnt); end
    endtask

    task automatic test_overwrite_err();
        write_word(2'd2, 32'h5);
        checks++; if (bus.overwrite_err !== 1'b0) begin errors++; $display("FAIL ow_first_write: got %b required 0", bus.overwrite_err); end
        write_word(2'd2, 32'h5);
        checks++; if (bus.overwrite_err !== 1'b1) begin errors++; $display("FAIL ow_second_write: got %b required 1", bus.overwrite_err); end
        for (int i = 0; i < 3; i++) step();
        checks++; if (bus.overwrite_err !== 1'b1) begin errors++; $display("FAIL ow_sticky: got %b required 1", bus.overwrite_err); end
    endtask

    task automatic test_reset_mid_pass();
        bit ok;
        checks++; if (bus.overwrite_err !== 1'b1) begin errors++; $display("FAIL rmp_err_before_reset: got %b required 1", bus.overwrite_err); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (bus.overwrite_err !== 1'b0) begin errors++; $display("FAIL rmp_err_cleared: got %b required 0", bus.overwrite_err); end
        bus.out_ready = 1'b0;
        write_word(2'd0, 32'h10);
        write_word(2'd1, 32'h20);
        expect_word(2'd0, 32'h10);
        start_pass();
        wait_valid(10, ok);
        checks++; if (!ok || bus.out_addr !== 2'd0) begin errors++; $display("FAIL rmp_first: got valid %b addr %0d required 1 0", ok, bus.out_addr); end
        bus.rd_start  = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL rmp_scan: got valid %b busy %b required 0 1", bus.out_valid, bus.busy); end
        step();
        bus.rd_start = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_addr !== 2'd1 || bus.out_data !== 32'h20) begin errors++; $display("FAIL rmp_start_ignored: got valid %b addr %0d data %h required 1 1 20", bus.out_valid, bus.out_addr, bus.out_data); end
        checks++; if (bus.rd_cnt !== 8'd1) begin errors++; $display("FAIL rmp_cnt_before: got %0d required 1", bus.rd_cnt); end
        reset = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rd_cnt !== '0) begin errors++; $display("FAIL rmp_after_reset: got valid %b busy %b cnt %0d required 0 0 0", bus.out_valid, bus.busy, bus.rd_cnt); end
        reset = 1'b0;
        bus.out_ready = 1'b1;
        start_pass();
        for (int i = 0; i < 5; i++) step();
        checks++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL rmp_empty_scan: got valid %b busy %b required 0 1", bus.out_valid, bus.busy); end
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_counter_wrap();
        bit ok;
        int target;
        bus.out_ready = 1'b1;
        for (int p = 0; p < 64; p++) begin
            for (int i = 0; i < 4; i++) begin
                write_word(ADDR_W'(i), {p[15:0], 16'(i)});
                expect_word(ADDR_W'(i), {p[15:0], 16'(i)});
            end
            target = hs_cnt + 4;
            start_pass();
            wait_hs(target, 40, ok);
            checks++; if (!ok) begin errors++; $display("FAIL wrap_pass_timeout: pass %0d got %0d handshakes required %0d", p, hs_cnt, target); end
            if (p == 62) begin
                checks++; if (bus.rd_cnt !== 8'd252) begin errors++; $display("FAIL wrap_cnt_252: got %0d required 252", bus.rd_cnt); end
            end
        end
        checks++; if (bus.rd_cnt !== 8'd0) begin errors++; $display("FAIL wrap_cnt_256: got %0d required 0", bus.rd_cnt); end
        write_word(2'd0, 32'hCAFE);
        expect_word(2'd0, 32'hCAFE);
        target = hs_cnt + 1;
        start_pass();
        wait_hs(target, 20, ok);
        checks++; if (!ok || bus.rd_cnt !== 8'd1) begin errors++; $display("FAIL wrap_cnt_257: got ok %b cnt %0d required 1 1", ok, bus.rd_cnt); end
        checks++; if (bus.rd_cnt !== exp_cnt) begin errors++; $display("FAIL wrap_model: got %0d required %0d", bus.rd_cnt, exp_cnt); end
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rd_start  = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic_pass();
        test_writer_paced();
        test_backpressure();
        test_overwrite_err();
        test_reset_mid_pass();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
